buffer_wr_ctrl: RTL and testbench

BUFFER_WR_CTRL -- requirements
Module: buffer_wr_ctrl

---
 rtl/buffer_ctrl_pkg.sv | 23 ++
 rtl/buffer_wr_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_buffer_wr_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_ctrl_pkg.sv
// Shared definitions for the buffer write controller: FSM states, word size,
// default geometry and the modulo-SIZE address helper.
package buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int WORD_BYTES   = 4;
    localparam int DEFAULT_SIZE = 64;
    localparam int DEFAULT_WIN  = 16;
    localparam int ADR_W        = 8;

    // SIZE is a power of two, so wrapping is a mask; the 9-bit sum keeps the carry out of 255.
    function automatic logic [ADR_W-1:0] wrap_adr(input logic [ADR_W:0] sum, input int size);
        logic [ADR_W:0] mask;
        mask = (ADR_W+1)'(size - 1);
        return ADR_W'(sum & mask);
    endfunction

endpackage

// File: rtl/buffer_wr_ctrl.sv
// Write-side controller for a circular byte buffer: accepts 32-bit words from a
// producer, writes them at a wrapping pointer and tracks occupancy against releases.
module buffer_wr_ctrl
    import buffer_ctrl_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int WIN  = DEFAULT_WIN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [7:0]            wr_adr,
    output logic [31:0]           wr_data,
    input  logic                  rd_adv,
    input  logic [$clog2(SIZE):0] rd_cnt,
    output logic [7:0]            rd_base,
    output logic [$clog2(SIZE):0] count,
    output logic                  full,
    output logic                  win_ok,
    output logic                  err
);

    localparam int CW = $clog2(SIZE) + 1;
    localparam int MW = 10;

    if (SIZE < WORD_BYTES || SIZE > 256 || (SIZE % WORD_BYTES) != 0 || (SIZE & (SIZE - 1)) != 0) begin : g_size_check
        $error("buffer_wr_ctrl: SIZE must be a power of 2, a multiple of 4 and at most 256");
    end

    state_t          r_state;
    state_t          w_state_next;

    logic            r_wr_en;
    logic [31:0]     r_wr_data;
    logic [7:0]      r_wr_ptr;
    logic [7:0]      r_rd_base;
    logic [CW-1:0]   r_count;
    logic            r_err;

    logic            w_wr_fire;
    logic            w_accept;
    logic            w_in_ready;
    logic [MW-1:0]   w_room_used;
    logic [CW-1:0]   w_rd_eff;
    logic            w_rd_under;
    logic [MW-1:0]   w_count_sum;
    logic [7:0]      w_wr_ptr_inc;
    logic [7:0]      w_rd_base_inc;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_state_next = FLUSH;
                end else if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath combinational terms
    // ------------------------------------------------------------------
    // A write registered in the same cycle as a flush never reaches the buffer.
    assign w_wr_fire = r_wr_en && (r_state != FLUSH);

    // Room for one more word must account for the word already in flight.
    assign w_room_used = MW'(r_count)
                       + (w_wr_fire ? MW'(WORD_BYTES) : '0)
                       + MW'(WORD_BYTES);
    assign w_in_ready  = (r_state == RUN) && (w_room_used <= MW'(SIZE));
    assign w_accept    = in_valid && w_in_ready;

    // Releases are clamped to the bytes already resident; the in-flight write is not releasable.
    always_comb begin
        w_rd_eff   = '0;
        w_rd_under = 1'b0;
        if (rd_adv && (r_state != FLUSH)) begin
            if (rd_cnt > r_count) begin
                w_rd_eff   = r_count;
                w_rd_under = 1'b1;
            end else begin
                w_rd_eff   = rd_cnt;
            end
        end
    end

    assign w_count_sum   = MW'(r_count)
                         + (w_wr_fire ? MW'(WORD_BYTES) : '0)
                         - MW'(w_rd_eff);
    assign w_wr_ptr_inc  = wrap_adr(9'(r_wr_ptr) + 9'(WORD_BYTES), SIZE);
    assign w_rd_base_inc = wrap_adr(9'(r_rd_base) + 9'(w_rd_eff), SIZE);

    // ------------------------------------------------------------------
    // Write port register: one-cycle latency from accept to buffer write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_data <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and sticky underflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_base <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else if (r_state == FLUSH) begin
            r_wr_ptr  <= '0;
            r_rd_base <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            r_rd_base <= w_rd_base_inc;
            r_count   <= w_count_sum[CW-1:0];
            if (w_rd_under) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready = w_in_ready;
    assign wr_en    = w_wr_fire;
    assign wr_adr   = r_wr_ptr;
    assign wr_data  = r_wr_data;
    assign rd_base  = r_rd_base;
    assign count    = r_count;
    assign full     = (r_count == CW'(SIZE));
    assign win_ok   = (MW'(r_count) >= MW'(WIN));
    assign err      = r_err;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= CW'(SIZE));
    a_adr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        r_wr_ptr[1:0] == 2'b00);

endmodule

// File: tb/tb_buffer_wr_ctrl.sv
// Self-checking bench for buffer_wr_ctrl: directed scenarios plus a randomized run
// against a byte-queue reference model and a mirror of the buffer memory.
module tb_buffer_wr_ctrl;

    localparam int SIZE = 64;
    localparam int WIN  = 16;
    localparam int CW   = $clog2(SIZE) + 1;

    logic          clk = 1'b0;
    logic          rst_n, start, flush, in_valid, rd_adv;
    logic [31:0]   in_data;
    logic [CW-1:0] rd_cnt;
    logic          in_ready, wr_en, full, win_ok, err;
    logic [7:0]    wr_adr, rd_base;
    logic [31:0]   wr_data;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffer_wr_ctrl #(.SIZE(SIZE), .WIN(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
        .rd_adv(rd_adv), .rd_cnt(rd_cnt), .rd_base(rd_base),
        .count(count), .full(full), .win_ok(win_ok), .err(err)
    );

    // Reference model: buffer contents as a byte queue, pointers as running totals.
    int         m_state;      // 0 idle, 1 run, 2 flush
    logic [7:0] m_q[$];
    int         m_wcount;     // words written since last clear
    int         m_rel;        // bytes released since last clear
    bit         m_err;
    bit         m_pend;
    logic [31:0] m_data;
    logic [7:0] mem [SIZE];

    function automatic bit exp_wr_en();
        return m_pend && (m_state != 2);
    endfunction

    function automatic int exp_count();
        return m_q.size();
    endfunction

    function automatic bit exp_in_ready();
        return (m_state == 1) && ((SIZE - exp_count() - 4 * int'(exp_wr_en())) >= 4);
    endfunction

    task automatic model_step();
        bit we, acc;
        int n;
        we  = exp_wr_en();
        acc = in_valid && exp_in_ready();
        if (!rst_n) begin
            m_state = 0; m_q.delete(); m_wcount = 0; m_rel = 0; m_err = 0; m_pend = 0;
        end else if (m_state == 2) begin
            m_state = 0; m_q.delete(); m_wcount = 0; m_rel = 0; m_err = 0; m_pend = 0;
        end else begin
            if (rd_adv) begin
                if (int'(rd_cnt) > m_q.size()) begin
                    n = m_q.size();
                    m_err = 1;
                end else begin
                    n = int'(rd_cnt);
                end
                repeat (n) void'(m_q.pop_front());
                m_rel += n;
            end
            if (we) begin
                for (int i = 0; i < 4; i++) m_q.push_back(m_data[31-8*i -: 8]);
                m_wcount++;
            end
            m_pend = acc;
            if (acc) m_data = in_data;
            if (flush) m_state = 2;
            else if (m_state == 0 && start) m_state = 1;
        end
    endtask

    // One clock: capture the buffer write the DUT presents, advance the model, move to next negedge.
    task automatic step();
        if (wr_en === 1'b1)
            for (int i = 0; i < 4; i++) mem[(int'(wr_adr) + i) % SIZE] = wr_data[31-8*i -: 8];
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        rst_n = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; rd_adv = 1'b0; rd_cnt = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0; in_valid = 1'b1; start = 1'b1;
        step(); step();
        drive_idle();
        $display("reset: count=%0d in_ready=%b wr_en=%b", count, in_ready, wr_en);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (wr_adr !== 8'd0) begin errors++; $display("FAIL reset_wr_adr got %0d want 0", wr_adr); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (rd_base !== 8'd0) begin errors++; $display("FAIL reset_rd_base got %0d want 0", rd_base); end
        checks++; if ({full, win_ok, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {full, win_ok, err}); end
    endtask

    task automatic test_fill();
        int k = 0;
        int w = 0;
        start = 1'b1; step(); start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (wr_en === 1'b1) begin
                $display("fill: wr adr=%0d data=%h count=%0d", wr_adr, wr_data, count);
                checks++; if (wr_adr !== 8'(4 * w)) begin errors++; $display("FAIL fill_adr got %0d want %0d", wr_adr, 4 * w); end
                checks++; if (wr_data !== 32'h00010203 + 32'(w)) begin errors++; $display("FAIL fill_data got %h want %h", wr_data, 32'h00010203 + 32'(w)); end
                if (w == 15) begin
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_16th_pending got %b want 0", in_ready); end
                end
                w++;
            end
            checks++; if (count !== CW'(exp_count())) begin errors++; $display("FAIL fill_count got %0d want %0d", count, exp_count()); end
            in_valid = (k < 16);
            in_data  = 32'h00010203 + 32'(k);
            if (in_valid && in_ready === 1'b1) k++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (w != 16) begin errors++; $display("FAIL fill_writes got %0d want 16", w); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
        checks++; if (count !== CW'(64)) begin errors++; $display("FAIL fill_count_final got %0d want 64", count); end
        checks++; if (win_ok !== 1'b1) begin errors++; $display("FAIL fill_win_ok got %b want 1", win_ok); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got %b want 0", in_ready); end
    endtask

    task automatic test_wrap();
        rd_adv = 1'b1; rd_cnt = CW'(6); step(); rd_adv = 1'b0;
        $display("wrap: release 6 count=%0d rd_base=%0d", count, rd_base);
        checks++; if (count !== CW'(58)) begin errors++; $display("FAIL wrap_count got %0d want 58", count); end
        checks++; if (rd_base !== 8'd6) begin errors++; $display("FAIL wrap_rd_base got %0d want 6", rd_base); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = 32'hA5A50001; step(); in_valid = 1'b0;
        $display("wrap: wr adr=%0d data=%h", wr_adr, wr_data);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL wrap_wr_en got %b want 1", wr_en); end
        checks++; if (wr_adr !== 8'd0) begin errors++; $display("FAIL wrap_adr got %0d want 0", wr_adr); end
        checks++; if (wr_data !== 32'hA5A50001) begin errors++; $display("FAIL wrap_data got %h want a5a50001", wr_data); end
        step();
        checks++; if (count !== CW'(62)) begin errors++; $display("FAIL wrap_count_after got %0d want 62", count); end
    endtask

    task automatic test_simul();
        rd_adv = 1'b1; rd_cnt = CW'(2); step(); rd_adv = 1'b0;
        checks++; if (count !== CW'(60)) begin errors++; $display("FAIL simul_count_pre got %0d want 60", count); end
        in_valid = 1'b1; in_data = 32'h0BADF00D; step(); in_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_adr !== 8'd4) begin errors++; $display("FAIL simul_inflight got en=%b adr=%0d want en=1 adr=4", wr_en, wr_adr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL simul_ready got %b want 0", in_ready); end
        rd_adv = 1'b1; rd_cnt = CW'(8); step(); rd_adv = 1'b0;
        $display("simul: write+release 8 count=%0d rd_base=%0d err=%b", count, rd_base, err);
        checks++; if (count !== CW'(56)) begin errors++; $display("FAIL simul_count got %0d want 56", count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL simul_err got %b want 0", err); end
        checks++; if (rd_base !== 8'd16) begin errors++; $display("FAIL simul_rd_base got %0d want 16", rd_base); end
    endtask

    task automatic test_underflow();
        rd_adv = 1'b1; rd_cnt = CW'(52); step();
        checks++; if (count !== CW'(4) || rd_base !== 8'd4) begin errors++; $display("FAIL under_pre got count=%0d base=%0d want 4 4", count, rd_base); end
        rd_cnt = CW'(10); step(); rd_adv = 1'b0;
        $display("underflow: release 10 of 4 count=%0d rd_base=%0d err=%b", count, rd_base, err);
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL under_count got %0d want 0", count); end
        checks++; if (rd_base !== 8'd8) begin errors++; $display("FAIL under_rd_base got %0d want 8", rd_base); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL under_err got %b want 1", err); end
        repeat (3) step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL under_err_sticky got %b want 1", err); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 32'h11112222; step();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL flush_first_write got %b want 1", wr_en); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_pre got %b want 1", in_ready); end
        in_data = 32'h33334444; flush = 1'b1; step(); flush = 1'b0; in_valid = 1'b0;
        $display("flush: flush cycle wr_en=%b count=%0d", wr_en, count);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL flush_suppress got %b want 0", wr_en); end
        step();
        checks++; if (count !== CW'(0) || rd_base !== 8'd0 || wr_adr !== 8'd0) begin errors++; $display("FAIL flush_clear got count=%0d base=%0d adr=%0d want 0 0 0", count, rd_base, wr_adr); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err got %b want 0", err); end
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got %b want 0", in_ready); end
            step();
        end
        checks++; if (wr_en !== 1'b0 || count !== CW'(0)) begin errors++; $display("FAIL flush_idle_nowrite got en=%b count=%0d want 0 0", wr_en, count); end
        in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_restart_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 32'hCAFE0001; step();
        in_data = 32'hCAFE0002; step();
        checks++; if (count !== CW'(4) || wr_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre got count=%0d en=%b want 4 1", count, wr_en); end
        in_data = 32'hCAFE0003; rst_n = 1'b0; step(); rst_n = 1'b1; in_valid = 1'b0;
        $display("reset_mid: wr_en=%b count=%0d wr_data=%h", wr_en, count, wr_data);
        checks++; if (wr_en !== 1'b0 || wr_adr !== 8'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL rstmid_write got en=%b adr=%0d data=%h want 0 0 0", wr_en, wr_adr, wr_data); end
        checks++; if (count !== CW'(0) || rd_base !== 8'd0 || in_ready !== 1'b0 || {full, win_ok, err} !== 3'b000) begin
            errors++; $display("FAIL rstmid_state got count=%0d base=%0d rdy=%b flags=%b want 0 0 0 000", count, rd_base, in_ready, {full, win_ok, err});
        end
    endtask

    task automatic test_random();
        bit offer = 0;
        bit mem_ok;
        for (int c = 0; c < 500; c++) begin
            checks++; if (count !== CW'(exp_count())) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count, exp_count()); end
            checks++; if (rd_base !== 8'(m_rel % SIZE)) begin errors++; $display("FAIL rand_rd_base cyc %0d got %0d want %0d", c, rd_base, m_rel % SIZE); end
            checks++; if (in_ready !== exp_in_ready()) begin errors++; $display("FAIL rand_in_ready cyc %0d got %b want %b", c, in_ready, exp_in_ready()); end
            checks++; if (wr_en !== exp_wr_en()) begin errors++; $display("FAIL rand_wr_en cyc %0d got %b want %b", c, wr_en, exp_wr_en()); end
            checks++; if (full !== (exp_count() == SIZE) || win_ok !== (exp_count() >= WIN)) begin errors++; $display("FAIL rand_levels cyc %0d got full=%b win=%b count_model=%0d", c, full, win_ok, exp_count()); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err cyc %0d got %b want %b", c, err, m_err); end
            if (exp_wr_en()) begin
                $display("rand: cyc %0d wr adr=%0d data=%h count=%0d", c, wr_adr, wr_data, count);
                checks++; if (wr_adr !== 8'((m_wcount * 4) % SIZE) || wr_data !== m_data) begin
                    errors++; $display("FAIL rand_write cyc %0d got adr=%0d data=%h want adr=%0d data=%h", c, wr_adr, wr_data, (m_wcount * 4) % SIZE, m_data);
                end
            end
            mem_ok = 1;
            for (int i = 0; i < exp_count(); i++)
                if (mem[(m_rel + i) % SIZE] !== m_q[i]) mem_ok = 0;
            checks++; if (!mem_ok) begin errors++; $display("FAIL rand_buffer_bytes cyc %0d got contents differing from model at base %0d", c, m_rel % SIZE); end

            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if (!offer) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = $urandom;
            end
            offer  = in_valid && !exp_in_ready();
            rd_adv = ($urandom_range(0, 3) == 0);
            rd_cnt = ($urandom_range(0, 15) == 0) ? CW'($urandom_range(0, SIZE + 4))
                                                  : CW'($urandom_range(0, 12));
            step();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_wrap();
        test_simul();
        test_underflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
